// File: rtl/game_layer_compositor.sv
// game_layer_compositor: per-pixel layer select with masks,
// frame-synchronous blink and a blank hold after state changes.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   state           current game state (16 table entries)
//   h_cnt, v_cnt    VGA scan position
//   layer_valid     bit i: layer i covers this pixel
//   layer_addr      layer i address at [i*ADDR_W +: ADDR_W]
//   cfg_we          mask table write strobe
//   cfg_state       table entry to write
//   cfg_mask        layer enable bits for that entry
//   cfg_blink       layer blink bits for that entry
//   pixel_addr      address of the winning layer (0 if blank)
//   notBlank        a layer was selected
//   layer_id        index of the winning layer (0 if blank)
//   frame_tick      one-cycle pulse per frame start
module game_layer_compositor #(
    parameter int NUM_LAYERS   = 4,
    parameter int ADDR_W       = 17,
    parameter int BLINK_FRAMES = 30,
    parameter int HOLD_FRAMES  = 2,
    parameter int H_VIS        = 640,
    parameter int V_VIS        = 480,
    localparam int ID_W =
        (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   state,
    input  logic [9:0]                   h_cnt,
    input  logic [9:0]                   v_cnt,
    input  logic [NUM_LAYERS-1:0]        layer_valid,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    input  logic                         cfg_we,
    input  logic [3:0]                   cfg_state,
    input  logic [NUM_LAYERS-1:0]        cfg_mask,
    input  logic [NUM_LAYERS-1:0]        cfg_blink,
    output logic [ADDR_W-1:0]            pixel_addr,
    output logic                         notBlank,
    output logic [ID_W-1:0]              layer_id,
    output logic                         frame_tick
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] HOLD_INIT  = 8'(HOLD_FRAMES);
    localparam logic [9:0] H_LIM      = 10'(H_VIS);
    localparam logic [9:0] V_LIM      = 10'(V_VIS);

    logic [NUM_LAYERS-1:0] mask_tbl  [16];
    logic [NUM_LAYERS-1:0] blink_tbl [16];

    logic [3:0] prev_state;
    logic [9:0] prev_h;
    logic [9:0] prev_v;
    logic [7:0] hold_cnt;
    logic [7:0] blink_cnt;
    logic       blink_phase;

    logic [NUM_LAYERS-1:0] s1_eff;
    logic [ADDR_W-1:0]     s1_addr [NUM_LAYERS];

    logic                  frame_start;
    logic                  state_chg;
    logic                  in_vis;
    logic [NUM_LAYERS-1:0] blink_kill;
    logic [NUM_LAYERS-1:0] eff_next;

    logic              sel_hit;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic              blank;

    // Comparing against the previous position makes a slow pixel
    // clock (position held for several clk) give a single start.
    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0) &&
                         ((prev_h != 10'd0) || (prev_v != 10'd0));
    assign state_chg   = (state != prev_state);

    assign in_vis     = (h_cnt < H_LIM) && (v_cnt < V_LIM);
    assign blink_kill = blink_tbl[state] &
                        {NUM_LAYERS{blink_phase}};
    assign eff_next   = in_vis ?
                        (layer_valid & mask_tbl[state] & ~blink_kill) :
                        '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mask_tbl[i]  <= '1;
                blink_tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            mask_tbl[cfg_state]  <= cfg_mask;
            blink_tbl[cfg_state] <= cfg_blink;
        end
    end

    // A state change wins over a coincident frame start, so that
    // frame does not count towards the hold or the blink period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state  <= 4'd0;
            prev_h      <= 10'd0;
            prev_v      <= 10'd0;
            frame_tick  <= 1'b0;
            hold_cnt    <= HOLD_INIT;
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else begin
            prev_state <= state;
            prev_h     <= h_cnt;
            prev_v     <= v_cnt;
            frame_tick <= frame_start;
            if (state_chg) begin
                hold_cnt    <= HOLD_INIT;
                blink_cnt   <= 8'd0;
                blink_phase <= 1'b0;
            end else if (frame_start) begin
                if (hold_cnt != 8'd0) begin
                    hold_cnt <= hold_cnt - 8'd1;
                end
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= 8'd0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_eff <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                s1_addr[i] <= '0;
            end
        end else begin
            s1_eff <= eff_next;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                s1_addr[i] <= layer_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Scan from the lowest priority upward so layer 0 wins last.
    always_comb begin
        sel_hit  = 1'b0;
        sel_id   = '0;
        sel_addr = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_eff[i]) begin
                sel_hit  = 1'b1;
                sel_id   = ID_W'(i);
                sel_addr = s1_addr[i];
            end
        end
    end

    assign blank = !sel_hit || (hold_cnt != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr <= '0;
            notBlank   <= 1'b0;
            layer_id   <= '0;
        end else if (blank) begin
            pixel_addr <= '0;
            notBlank   <= 1'b0;
            layer_id   <= '0;
        end else begin
            pixel_addr <= sel_addr;
            notBlank   <= 1'b1;
            layer_id   <= sel_id;
        end
    end

endmodule
